mem_arbiter: RTL and testbench

Shares the single external memory bus port between the instruction-fetch requester (IF) and the load/store requester (MEM stage). Each requester uses a request/acknowledge handshake, and each bus transfer runs to completion before the next is granted. The block also raises a pipeline stall request while any requester is waiting. It sits between the IF/MEM pipeline stages and the memory bus, and feeds the stall controller.

---
 rtl/mem_arbiter.sv | 177 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester memory bus arbiter (IF fetch vs MEM load/store).
// Define ARB_RR_EN for round-robin ties; default is fixed MEM priority.
module mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic [DW-1:0] if_data_o,
  output logic          if_ack_o,
  input  logic          mem_req_i,
  input  logic          mem_we_i,
  input  logic [3:0]    mem_sel_i,
  input  logic [AW-1:0] mem_addr_i,
  input  logic [DW-1:0] mem_data_i,
  output logic [DW-1:0] mem_data_o,
  output logic          mem_ack_o,
  output logic          bus_req_o,
  output logic          bus_we_o,
  output logic [3:0]    bus_sel_o,
  output logic [AW-1:0] bus_addr_o,
  output logic [DW-1:0] bus_data_o,
  input  logic [DW-1:0] bus_data_i,
  input  logic          bus_ack_i,
  output logic          stallreq_o
);

  typedef enum logic [1:0] {
    IDLE,
    IF_BUSY,
    MEM_BUSY
  } state_e;

  state_e        state_q, state_d;
  logic          bus_req_q, bus_req_d;
  logic          bus_we_q, bus_we_d;
  logic [3:0]    bus_sel_q, bus_sel_d;
  logic [AW-1:0] bus_addr_q, bus_addr_d;
  logic [DW-1:0] bus_data_q, bus_data_d;
  logic          if_ack_q, if_ack_d;
  logic          mem_ack_q, mem_ack_d;
  logic [DW-1:0] if_data_q, if_data_d;
  logic [DW-1:0] mem_data_q, mem_data_d;
  logic          if_elig;
  logic          mem_elig;
  logic          pick_mem;

`ifdef ARB_RR_EN
  logic last_mem_q, last_mem_d;
`endif

  // A requester in its ack cycle is not eligible, so a held req is not regranted
  assign if_elig  = if_req_i & ~if_ack_q;
  assign mem_elig = mem_req_i & ~mem_ack_q;

`ifdef ARB_RR_EN
  assign pick_mem = mem_elig & (~if_elig | ~last_mem_q);
`else
  assign pick_mem = mem_elig;
`endif

  always_comb begin
    state_d    = state_q;
    bus_req_d  = bus_req_q;
    bus_we_d   = bus_we_q;
    bus_sel_d  = bus_sel_q;
    bus_addr_d = bus_addr_q;
    bus_data_d = bus_data_q;
    if_ack_d   = 1'b0;
    mem_ack_d  = 1'b0;
    if_data_d  = if_data_q;
    mem_data_d = mem_data_q;
`ifdef ARB_RR_EN
    last_mem_d = last_mem_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_mem) begin
          state_d    = MEM_BUSY;
          bus_req_d  = 1'b1;
          bus_we_d   = mem_we_i;
          bus_sel_d  = mem_sel_i;
          bus_addr_d = mem_addr_i;
          bus_data_d = mem_data_i;
`ifdef ARB_RR_EN
          last_mem_d = 1'b1;
`endif
        end else if (if_elig) begin
          state_d    = IF_BUSY;
          bus_req_d  = 1'b1;
          bus_we_d   = 1'b0;
          bus_sel_d  = 4'b1111;
          bus_addr_d = if_addr_i;
`ifdef ARB_RR_EN
          last_mem_d = 1'b0;
`endif
        end
      end
      IF_BUSY: begin
        if (bus_ack_i) begin
          state_d   = IDLE;
          bus_req_d = 1'b0;
          // A dropped request still finishes on the bus but is not acked
          if (if_req_i) begin
            if_ack_d  = 1'b1;
            if_data_d = bus_data_i;
          end
        end
      end
      MEM_BUSY: begin
        if (bus_ack_i) begin
          state_d   = IDLE;
          bus_req_d = 1'b0;
          if (mem_req_i) begin
            mem_ack_d  = 1'b1;
            mem_data_d = bus_data_i;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        bus_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      bus_req_q  <= 1'b0;
      bus_we_q   <= 1'b0;
      bus_sel_q  <= '0;
      bus_addr_q <= '0;
      bus_data_q <= '0;
      if_ack_q   <= 1'b0;
      mem_ack_q  <= 1'b0;
      if_data_q  <= '0;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      bus_req_q  <= bus_req_d;
      bus_we_q   <= bus_we_d;
      bus_sel_q  <= bus_sel_d;
      bus_addr_q <= bus_addr_d;
      bus_data_q <= bus_data_d;
      if_ack_q   <= if_ack_d;
      mem_ack_q  <= mem_ack_d;
      if_data_q  <= if_data_d;
      mem_data_q <= mem_data_d;
    end
  end

`ifdef ARB_RR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_mem_q <= 1'b0;
    end else begin
      last_mem_q <= last_mem_d;
    end
  end
`endif

  assign bus_req_o  = bus_req_q;
  assign bus_we_o   = bus_we_q;
  assign bus_sel_o  = bus_sel_q;
  assign bus_addr_o = bus_addr_q;
  assign bus_data_o = bus_data_q;
  assign if_ack_o   = if_ack_q;
  assign mem_ack_o  = mem_ack_q;
  assign if_data_o  = if_data_q;
  assign mem_data_o = mem_data_q;

  assign stallreq_o = (if_req_i & ~if_ack_q) | (mem_req_i & ~mem_ack_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed cases plus random traffic
// checked against a transaction-level reference model.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req_i;
  logic [AW-1:0] if_addr_i;
  logic [DW-1:0] if_data_o;
  logic          if_ack_o;
  logic          mem_req_i;
  logic          mem_we_i;
  logic [3:0]    mem_sel_i;
  logic [AW-1:0] mem_addr_i;
  logic [DW-1:0] mem_data_i;
  logic [DW-1:0] mem_data_o;
  logic          mem_ack_o;
  logic          bus_req_o;
  logic          bus_we_o;
  logic [3:0]    bus_sel_o;
  logic [AW-1:0] bus_addr_o;
  logic [DW-1:0] bus_data_o;
  logic [DW-1:0] bus_data_i;
  logic          bus_ack_i;
  logic          stallreq_o;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i),
    .if_data_o(if_data_o), .if_ack_o(if_ack_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i),
    .mem_sel_i(mem_sel_i), .mem_addr_i(mem_addr_i),
    .mem_data_i(mem_data_i), .mem_data_o(mem_data_o),
    .mem_ack_o(mem_ack_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
    .bus_sel_o(bus_sel_o), .bus_addr_o(bus_addr_o),
    .bus_data_o(bus_data_o), .bus_data_i(bus_data_i),
    .bus_ack_i(bus_ack_i), .stallreq_o(stallreq_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [3:0]    sel;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } bus_t;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: transaction-level view of who owns the bus
  bit            m_busy, m_own_mem, m_if_ack, m_mem_ack;
  bit            el_i, el_m, gm, nif, nmem;
  logic [DW-1:0] m_bdata = '0;
  bus_t          bus_q[$];
  logic [DW-1:0] if_q[$];
  logic [DW-1:0] mem_q[$];
  bus_t          tmp;
`ifdef ARB_RR_EN
  bit            m_last_mem;
`endif

  task automatic model_clear();
    m_busy = 0; m_own_mem = 0; m_if_ack = 0; m_mem_ack = 0;
    m_bdata = '0;
`ifdef ARB_RR_EN
    m_last_mem = 0;
`endif
    bus_q.delete(); if_q.delete(); mem_q.delete();
  endtask

  initial forever begin
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      nif = 0; nmem = 0;
      if (!m_busy) begin
        el_i = if_req_i && !m_if_ack;
        el_m = mem_req_i && !m_mem_ack;
`ifdef ARB_RR_EN
        gm = el_m && (!el_i || !m_last_mem);
`else
        gm = el_m;
`endif
        if (gm) begin
          m_bdata = mem_data_i;
          tmp = '{we: mem_we_i, sel: mem_sel_i, addr: mem_addr_i, data: mem_data_i};
          bus_q.push_back(tmp);
          m_busy = 1; m_own_mem = 1;
`ifdef ARB_RR_EN
          m_last_mem = 1;
`endif
        end else if (el_i) begin
          tmp = '{we: 1'b0, sel: 4'hF, addr: if_addr_i, data: m_bdata};
          bus_q.push_back(tmp);
          m_busy = 1; m_own_mem = 0;
`ifdef ARB_RR_EN
          m_last_mem = 0;
`endif
        end
      end else if (bus_ack_i) begin
        m_busy = 0;
        if (m_own_mem && mem_req_i) begin
          nmem = 1; mem_q.push_back(bus_data_i);
        end
        if (!m_own_mem && if_req_i) begin
          nif = 1; if_q.push_back(bus_data_i);
        end
      end
      m_if_ack = nif; m_mem_ack = nmem;
    end
  end

  // Monitor: pops expectations whenever the DUT presents a grant or ack
  logic prev_req;
  bus_t prev_f;
  bus_t e;
  logic [DW-1:0] ed;
  initial begin
    prev_req = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_req = 0;
      end else begin
        chk("bus_req", bus_req_o, m_busy);
        chk("if_ack", if_ack_o, m_if_ack);
        chk("mem_ack", mem_ack_o, m_mem_ack);
        chk("stallreq", stallreq_o,
            (if_req_i & ~m_if_ack) | (mem_req_i & ~m_mem_ack));
        if (bus_req_o && !prev_req) begin
          chk("grant_expected", bus_q.size() != 0, 1);
          if (bus_q.size() != 0) begin
            e = bus_q.pop_front();
            chk("grant_we", bus_we_o, e.we);
            chk("grant_sel", bus_sel_o, e.sel);
            chk("grant_addr", bus_addr_o, e.addr);
            chk("grant_data", bus_data_o, e.data);
          end
        end else if (bus_req_o) begin
          chk("hold_fields", {bus_we_o, bus_sel_o, bus_addr_o},
              {prev_f.we, prev_f.sel, prev_f.addr});
          chk("hold_data", bus_data_o, prev_f.data);
        end
        if (if_ack_o) begin
          chk("if_ack_expected", if_q.size() != 0, 1);
          if (if_q.size() != 0) begin
            ed = if_q.pop_front();
            chk("if_data", if_data_o, ed);
          end
        end
        if (mem_ack_o) begin
          chk("mem_ack_expected", mem_q.size() != 0, 1);
          if (mem_q.size() != 0) begin
            ed = mem_q.pop_front();
            chk("mem_data", mem_data_o, ed);
          end
        end
        prev_req = bus_req_o;
        prev_f = '{we: bus_we_o, sel: bus_sel_o, addr: bus_addr_o, data: bus_data_o};
      end
    end
  end

  // Bus slave and random requesters
  bit            rnd = 0, spur_en = 0, slave_en = 1, fdata_en = 0;
  int            fwait = -1;
  logic [DW-1:0] fdata = '0;
  bit            started = 0;
  int            wcnt = 0;

  initial forever begin
    @(posedge clk); #1;
    if (rst) begin
      bus_ack_i = 0; started = 0;
    end else if (!bus_req_o) begin
      started = 0;
      bus_ack_i = spur_en && ($urandom_range(7) == 0);
      bus_data_i = $urandom;
    end else begin
      if (!started) begin
        started = 1;
        wcnt = (fwait >= 0) ? fwait : int'($urandom_range(3));
      end
      if (!slave_en) begin
        bus_ack_i = 0;
      end else if (wcnt == 0) begin
        bus_ack_i = 1;
        bus_data_i = fdata_en ? fdata : $urandom;
      end else begin
        wcnt--; bus_ack_i = 0;
      end
    end
    if (rnd) begin
      if (!if_req_i) begin
        if ($urandom_range(3) == 0) begin
          if_req_i = 1; if_addr_i = $urandom;
        end
      end else if (if_ack_o) begin
        if ($urandom_range(1) == 0) if_req_i = 0;
        else if_addr_i = $urandom;
      end else if ($urandom_range(15) == 0) begin
        if_req_i = 0;
      end
      if (!mem_req_i) begin
        if ($urandom_range(3) == 0) begin
          mem_req_i = 1; mem_we_i = $urandom_range(1);
          mem_sel_i = $urandom_range(15); mem_addr_i = $urandom;
          mem_data_i = $urandom;
        end
      end else if (mem_ack_o) begin
        if ($urandom_range(1) == 0) mem_req_i = 0;
        else begin
          mem_we_i = $urandom_range(1); mem_sel_i = $urandom_range(15);
          mem_addr_i = $urandom; mem_data_i = $urandom;
        end
      end else if ($urandom_range(15) == 0) begin
        mem_req_i = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_ack(input bit mem, output int n);
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!(mem ? mem_ack_o : if_ack_o) && n < 50);
  endtask

  task automatic tie_run(input logic [AW-1:0] ia, input logic [AW-1:0] ma,
                         output int g0, output int g1, output int gap);
    bit idone, mdone, pr;
    int grants;
    g0 = -1; g1 = -1; gap = 0; grants = 0;
    pr = 0; idone = 0; mdone = 0;
    tick();
    if_req_i = 1; if_addr_i = ia;
    mem_req_i = 1; mem_we_i = 1; mem_sel_i = 4'hF;
    mem_addr_i = ma; mem_data_i = $urandom;
    for (int c = 0; c < 40 && !(idone && mdone); c++) begin
      @(negedge clk);
      if (bus_req_o && !pr) begin
        if (grants == 0) g0 = int'(bus_we_o);
        else g1 = int'(bus_we_o);
        grants++;
      end
      if (!bus_req_o && grants == 1) gap++;
      pr = bus_req_o;
      if (mem_ack_o) mdone = 1;
      if (if_ack_o) idone = 1;
      tick();
      if (mdone) mem_req_i = 0;
      if (idone) if_req_i = 0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  int n, g0, g1, gap, acks;

  initial begin
    rst = 1; if_req_i = 0; if_addr_i = '0; mem_req_i = 0;
    mem_we_i = 0; mem_sel_i = '0; mem_addr_i = '0; mem_data_i = '0;
    bus_data_i = '0; bus_ack_i = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_bus_req", bus_req_o, 0);
    chk("rst_bus_we", bus_we_o, 0);
    chk("rst_bus_sel", bus_sel_o, 0);
    chk("rst_bus_addr", bus_addr_o, 0);
    chk("rst_bus_data", bus_data_o, 0);
    chk("rst_acks", {if_ack_o, mem_ack_o}, 0);
    chk("rst_if_data", if_data_o, 0);
    chk("rst_mem_data", mem_data_o, 0);
    chk("rst_stall", stallreq_o, 0);
    tick(); rst = 0;
    tick(); tick();

    // Single IF read, three wait states, held through its ack cycle
    fwait = 3; fdata = 32'hDEADBEEF; fdata_en = 1;
    tick(); if_req_i = 1; if_addr_i = 32'h0000_4000;
    wait_ack(0, n);
    chk("t1_latency", n, 6);
    chk("t1_data", if_data_o, 32'hDEADBEEF);
    chk("t1_addr", bus_addr_o, 32'h0000_4000);
    chk("t1_we", bus_we_o, 0);
    chk("t1_sel", bus_sel_o, 4'hF);
    tick(); if_req_i = 0;
    @(negedge clk);
    chk("t1_no_regrant", bus_req_o, 0);
    chk("t1_single_ack", if_ack_o, 0);

    // MEM store, zero-wait bus
    fwait = 0; fdata_en = 0;
    tick();
    mem_req_i = 1; mem_we_i = 1; mem_sel_i = 4'b0011;
    mem_addr_i = 32'h100; mem_data_i = 32'h12345678;
    wait_ack(1, n);
    chk("t2_latency", n, 3);
    chk("t2_we", bus_we_o, 1);
    chk("t2_sel", bus_sel_o, 4'b0011);
    chk("t2_addr", bus_addr_o, 32'h100);
    chk("t2_data", bus_data_o, 32'h12345678);
    tick(); mem_req_i = 0;
    tick();

    // Simultaneous requests, twice
    tie_run(32'h2000, 32'h3000, g0, g1, gap);
    chk("tie1_first_mem", g0, 1);
    chk("tie1_second_if", g1, 0);
    chk("tie1_gap", gap, 1);
    fwait = 2;
    tie_run(32'h2004, 32'h3004, g0, g1, gap);
    chk("tie2_first_mem", g0, 1);
    chk("tie2_second_if", g1, 0);
    chk("tie2_gap", gap, 1);

    // Random traffic against the reference model
    fwait = -1; spur_en = 1; rnd = 1;
    repeat (3000) @(posedge clk);
    @(negedge clk); rnd = 0;
    tick(); if_req_i = 0; mem_req_i = 0; spur_en = 0;
    repeat (10) tick();

    // MEM drops its request mid-transfer
    fwait = 3;
    tick();
    mem_req_i = 1; mem_we_i = 0; mem_sel_i = 4'hF; mem_addr_i = 32'h200;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus_req_o && n < 10);
    chk("t5_granted", bus_req_o, 1);
    tick(); mem_req_i = 0;
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (mem_ack_o) acks++;
    end
    chk("t5_no_ack", acks, 0);
    chk("t5_idle", bus_req_o, 0);

    // Asynchronous reset while the MEM transfer is in flight
    slave_en = 0;
    tick();
    mem_req_i = 1; mem_we_i = 1; mem_sel_i = 4'hF;
    mem_addr_i = 32'h300; mem_data_i = 32'h55AA55AA;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus_req_o && n < 10);
    chk("t6_granted", bus_req_o, 1);
    @(posedge clk); #3;
    rst = 1; mem_req_i = 0; model_clear();
    #1;
    chk("t6_bus_req", bus_req_o, 0);
    chk("t6_acks", {if_ack_o, mem_ack_o}, 0);
    chk("t6_bus_addr", bus_addr_o, 0);
    chk("t6_bus_we", bus_we_o, 0);
    tick(); rst = 0; slave_en = 1;
    fwait = 1; fdata = 32'hCAFEF00D; fdata_en = 1;
    tick(); if_req_i = 1; if_addr_i = 32'h0000_0040;
    wait_ack(0, n);
    chk("t6_if_latency", n, 4);
    chk("t6_if_data", if_data_o, 32'hCAFEF00D);
    chk("t6_if_addr", bus_addr_o, 32'h0000_0040);
    tick(); if_req_i = 0;
    repeat (4) tick();

    chk("sb_bus_empty", bus_q.size(), 0);
    chk("sb_if_empty", if_q.size(), 0);
    chk("sb_mem_empty", mem_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
